// File: rtl/pbg_pkg.sv
// Shared types and helpers for the pulse burst generator.
package pbg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } pbg_state_t;

  // Width that holds the longer phase length (and therefore any reload value).
  function automatic int timer_width(input int high_cycles, input int low_cycles);
    int longest;
    longest = (high_cycles > low_cycles) ? high_cycles : low_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/pulse_burst_gen_if.sv
// Control/status bundle between a burst requester and the pulse burst generator.
// Handshake: start is a level; a burst is accepted on any rising clk edge where
// start=1 and busy=0 (count is sampled on that edge only); done strobes one cycle
// when the burst has finished; start/count are ignored while busy=1.
interface pulse_burst_gen_if
  import pbg_pkg::*;
#(
  parameter int COUNT_W = 4
);
  logic               start;
  logic [COUNT_W-1:0] count;
  logic               pulse_out;
  logic               busy;
  logic               done;
  logic [COUNT_W-1:0] remaining;
  pbg_state_t         state;

  modport master (
    output start, count,
    input  pulse_out, busy, done, remaining, state
  );

  modport slave (
    input  start, count,
    output pulse_out, busy, done, remaining, state
  );
endinterface

// File: rtl/pulse_burst_gen_interval_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
module interval_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         expire
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign expire = (value == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Emits a burst of count fixed-width pulses; busy covers the burst, done strobes after.
module pulse_burst_gen
  import pbg_pkg::*;
#(
  parameter int HIGH_CYCLES = 2500000,
  parameter int LOW_CYCLES  = 2500000,
  parameter int COUNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  pulse_burst_gen_if.slave bus
);

  localparam int TW = timer_width(HIGH_CYCLES, LOW_CYCLES);
  // Phases last load+1 cycles because the timer expires on reaching zero.
  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);

  pbg_state_t         state, state_n;
  logic [COUNT_W-1:0] remaining, remaining_n;
  logic               pulse_q, busy_q, done_q;
  logic               tmr_load;
  logic [TW-1:0]      tmr_load_value;
  logic [TW-1:0]      tmr_value;
  logic               tmr_expire;

  interval_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .expire     (tmr_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      pulse_q   <= (state_n == HIGH);
      busy_q    <= (state_n == HIGH) || (state_n == LOW);
      done_q    <= (state_n == DONE);
    end
  end

  always_comb begin
    state_n        = state;
    remaining_n    = remaining;
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (bus.start) begin
          if (bus.count != '0) begin
            state_n        = HIGH;
            remaining_n    = bus.count;
            tmr_load       = 1'b1;
            tmr_load_value = HIGH_LOAD;
          end else begin
            state_n = DONE;
          end
        end
      end
      HIGH: begin
        if (tmr_expire) begin
          state_n        = LOW;
          tmr_load       = 1'b1;
          tmr_load_value = LOW_LOAD;
        end
      end
      LOW: begin
        if (tmr_expire) begin
          remaining_n = remaining - COUNT_W'(1);
          if (remaining == COUNT_W'(1)) begin
            state_n = DONE;
          end else begin
            state_n        = HIGH;
            tmr_load       = 1'b1;
            tmr_load_value = HIGH_LOAD;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining;
  assign bus.state     = state;

  // tmr_value is only observed through expire inside the FSM.
  logic unused_tmr;
  assign unused_tmr = ^tmr_value;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen with HIGH_CYCLES=3, LOW_CYCLES=2, COUNT_W=4.
module tb_pulse_burst_gen;
  import pbg_pkg::*;

  localparam int HC = 3;
  localparam int LC = 2;
  localparam int CW = 4;
  localparam int PER = HC + LC;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  pulse_burst_gen_if #(.COUNT_W(CW)) bus ();

  pulse_burst_gen #(
    .HIGH_CYCLES (HC),
    .LOW_CYCLES  (LC),
    .COUNT_W     (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_pulse"}, {31'd0, bus.pulse_out}, 32'd0);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_rem"}, {28'd0, bus.remaining}, 32'd0);
  endtask

  // Called one cycle after the accepting edge; checks the whole burst and its done cycle.
  task automatic check_burst(input string tag, input int n);
    int pos;
    for (int c = 1; c <= n * PER; c++) begin
      pos = (c - 1) % PER;
      chk({tag, "_pulse"}, {31'd0, bus.pulse_out}, (pos < HC) ? 32'd1 : 32'd0);
      chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
      chk({tag, "_done"}, {31'd0, bus.done}, 32'd0);
      chk({tag, "_rem"}, {28'd0, bus.remaining}, 32'(n - (c - 1) / PER));
      tick();
    end
    chk({tag, "_end_done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, "_end_busy"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, "_end_pulse"}, {31'd0, bus.pulse_out}, 32'd0);
    chk({tag, "_end_rem"}, {28'd0, bus.remaining}, 32'd0);
  endtask

  initial begin
    int pulses;
    int dones;
    logic prev_pulse;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.count = '0;

    // Power-on reset
    repeat (2) tick();
    chk_idle("por");
    chk("por_state", {30'd0, bus.state}, {30'd0, IDLE});
    rst = 1'b0;
    tick();
    chk_idle("post_rst");

    // Basic burst of 3
    bus.start = 1'b1;
    bus.count = 4'd3;
    tick();
    bus.start = 1'b0;
    bus.count = 4'd0;
    check_burst("basic3", 3);
    tick();
    chk_idle("basic3_after");

    // Zero count: done only
    bus.start = 1'b1;
    bus.count = 4'd0;
    tick();
    bus.start = 1'b0;
    chk_idle_done0: begin
      chk("zero_done", {31'd0, bus.done}, 32'd1);
      chk("zero_busy", {31'd0, bus.busy}, 32'd0);
      chk("zero_pulse", {31'd0, bus.pulse_out}, 32'd0);
      chk("zero_rem", {28'd0, bus.remaining}, 32'd0);
    end
    tick();
    chk_idle("zero_after");

    // Start/count while busy are ignored
    bus.start = 1'b1;
    bus.count = 4'd2;
    tick();
    bus.start = 1'b0;
    pulses = 0;
    dones = 0;
    prev_pulse = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (bus.pulse_out && !prev_pulse) pulses++;
      if (bus.done) dones++;
      prev_pulse = bus.pulse_out;
      if (c == 6) begin
        bus.start = 1'b1;
        bus.count = 4'd5;
      end else begin
        bus.start = 1'b0;
        bus.count = 4'd0;
      end
      tick();
    end
    chk("ign_pulses", 32'(pulses), 32'd2);
    chk("ign_dones", 32'(dones), 32'd1);
    chk_idle("ign_after");

    // Back-to-back at maximum count with start held
    bus.start = 1'b1;
    bus.count = 4'd15;
    tick();
    check_burst("max15", 15);
    tick();
    chk("b2b_pulse", {31'd0, bus.pulse_out}, 32'd1);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    chk("b2b_done", {31'd0, bus.done}, 32'd0);
    chk("b2b_rem", {28'd0, bus.remaining}, 32'd15);
    bus.start = 1'b0;
    bus.count = 4'd0;

    // Asynchronous reset between edges, during a high phase
    #2;
    rst = 1'b1;
    #1;
    chk_idle("async_rst");
    tick();
    rst = 1'b0;
    tick();
    chk_idle("async_rst_rel");

    // Reset during LOW of pulse 2 of a 4-pulse burst
    bus.start = 1'b1;
    bus.count = 4'd4;
    tick();
    bus.start = 1'b0;
    bus.count = 4'd0;
    repeat (8) tick();
    chk("mid_in_low_pulse", {31'd0, bus.pulse_out}, 32'd0);
    chk("mid_in_low_busy", {31'd0, bus.busy}, 32'd1);
    chk("mid_in_low_rem", {28'd0, bus.remaining}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    tick();
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.done || bus.busy) dones++;
      tick();
    end
    chk("mid_no_activity", 32'(dones), 32'd0);

    // Fresh full burst after abort
    bus.start = 1'b1;
    bus.count = 4'd4;
    tick();
    bus.start = 1'b0;
    bus.count = 4'd0;
    check_burst("fresh4", 4);
    tick();
    chk_idle("fresh4_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_burst_gen.md
# pulse_burst_gen

Generates a burst of N clean, fixed-width pulses on a single output pin on command. It is the transmit-side companion to the board's debounced press counter. It drives an input line (or a loopback) with pulses whose high and low times comfortably exceed the receiver's debounce window, so every emitted pulse is counted exactly once. It sits between a control source (switches or an FSM issuing start/count) and a board output pin.

## Interface
Parameters:
- HIGH_CYCLES, default 2500000: clk cycles pulse_out is held high per pulse; must be ≥1.
- LOW_CYCLES, default 2500000: clk cycles pulse_out is held low after each pulse, including after the last one; must be ≥1.
- COUNT_W, default 4: width of count and remaining.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: request a burst; level-sampled on each rising clk edge.
- count, in, COUNT_W: number of pulses; sampled only on the accepting edge.
- pulse_out, out, 1: registered pulse train.
- busy, out, 1: high while a burst is in progress (HIGH/LOW states).
- done, out, 1: one-cycle completion strobe.
- remaining, out, COUNT_W: pulses not yet completed in the current burst.

## Operation
- States:
  - IDLE: pulse_out=0, busy=0, done=0.
  - HIGH: pulse_out=1, busy=1.
  - LOW: pulse_out=0, busy=1.
  - DONE: pulse_out=0, busy=0, done=1, lasts exactly 1 cycle.
- Reset (asynchronous): state=IDLE, pulse_out=0, busy=0, done=0, remaining=0, timer=0.
  - Reset mid-burst aborts the burst immediately; no done strobe is issued.
- Start acceptance: start=1 in IDLE or DONE.
  - count≠0: latch remaining=count, go to HIGH, load timer.
  - count=0: go to DONE; no pulse; remaining stays 0.
- HIGH: after HIGH_CYCLES cycles, go to LOW.
- LOW: after LOW_CYCLES cycles, remaining decrements by 1.
  - If the new value of remaining is 0, go to DONE; otherwise go to HIGH.
- DONE: return to IDLE, unless start=1, which is accepted exactly as in IDLE. This allows back-to-back bursts.
- start while busy=1 is ignored; count changes while busy are ignored.
- count = 2^COUNT_W−1 is legal; remaining never wraps.
- Timer: down-counter of width $clog2(max(HIGH_CYCLES, LOW_CYCLES)+1). Reloaded on each state entry; the state transition fires on the cycle the timer reaches terminal count.

## Timing
- Accepting edge E (count≠0): pulse_out=1 and busy=1 visible after E.
- pulse_out high for exactly HIGH_CYCLES cycles, then low for exactly LOW_CYCLES cycles; the pattern repeats count times.
- busy high for exactly count×(HIGH_CYCLES+LOW_CYCLES) cycles.
- done high in the next cycle, with busy=0 in that same cycle.
- count=0: done high in the cycle after E; busy never rises.
- All outputs are registered; no combinational path from start or count to any output.

## Structure
- Shared package pbg_pkg holds:
  - the state enum (IDLE, HIGH, LOW, DONE);
  - a timer-width helper function.
- One natural sub-module: interval_timer, a loadable down-counter with load, value and expire signals, parameterized by width.
- Top-level FSM, remaining counter and output registers live in pulse_burst_gen.

## Test plan
All scenarios use HIGH_CYCLES=3, LOW_CYCLES=2.
- Reset:
  - Stimulus: assert rst asynchronously between clock edges.
  - Required: pulse_out=0, busy=0, done=0, remaining=0 immediately, without waiting for a clock edge.
- Basic burst:
  - Stimulus: start=1 for 1 cycle with count=3.
  - Required: pattern 111 00 repeated 3 times on pulse_out; busy high for exactly 15 cycles; done=1 for one cycle at cycle 16; remaining reads 3→2→1→0, each decrement at the end of a LOW phase.
- Zero count:
  - Stimulus: start with count=0.
  - Required: no pulse; busy stays 0; done=1 one cycle after the start edge.
- Ignored start and count:
  - Stimulus: start=1 with count=5 during the second pulse of a count=2 burst.
  - Required: exactly 2 pulses; exactly one done strobe.
- Back-to-back and maximum count:
  - Stimulus: hold start=1 continuously with count=15.
  - Required: 15 pulses, done for one cycle, and the next burst's first high begins on the cycle immediately after done; remaining never wraps.
- Reset mid-burst:
  - Stimulus: assert rst during the LOW phase of pulse 2 of a count=4 burst.
  - Required: pulse_out=0, busy=0, remaining=0; no done strobe; a fresh start then yields a full, correct burst.
